// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for a 5-stage pipeline: shadows the destination tags of
// in-flight instructions, issues registered EX operand selects and detects load-use stalls.
module hazard_fwd_unit #(
   parameter int unsigned REG_AW   = 3,
   parameter bit          ZERO_REG = 1'b0,
   parameter int unsigned PERF_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_ra,
   input  logic [REG_AW-1:0] id_rb,
   input  logic              id_use_ra,
   input  logic              id_use_rb,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              ex_flush,
   input  logic              freeze,
   output logic              stall,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [PERF_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      FwdReg  = 2'b00,
      FwdMem  = 2'b01,
      FwdWb   = 2'b10,
      FwdHold = 2'b11
   } fwd_sel_e;

   logic              exWe_q, exMr_q, memWe_q, wbWe_q;
   logic [REG_AW-1:0] exRd_q, memRd_q, wbRd_q;
   logic [1:0]        fwdA_q, fwdB_q;
   logic [PERF_W-1:0] stallCnt_q;

   logic       idWe, hazA, hazB, bubble;
   logic [1:0] selA, selB;

   // Newest producer wins; the EX match alone is qualified by the use flag.
   function automatic logic [1:0] selFwd(
      input logic              useSrc,
      input logic [REG_AW-1:0] rs,
      input logic              exWe,
      input logic [REG_AW-1:0] exRd,
      input logic              memWe,
      input logic [REG_AW-1:0] memRd,
      input logic              wbWe,
      input logic [REG_AW-1:0] wbRd
   );
      logic [1:0] sel;
      sel = FwdReg;
      if (useSrc && exWe && (rs == exRd)) begin
         sel = FwdMem;
      end else if (memWe && (rs == memRd)) begin
         sel = FwdWb;
      end else if (wbWe && (rs == wbRd)) begin
         sel = FwdHold;
      end
      return sel;
   endfunction

   always_comb begin
      idWe   = id_regwrite && !(ZERO_REG && (id_rd == '0));
      hazA   = id_use_ra && (id_ra == exRd_q);
      hazB   = id_use_rb && (id_rb == exRd_q);
      stall  = id_valid && !ex_flush && exWe_q && exMr_q && (hazA || hazB);
      bubble = stall || ex_flush || !id_valid;
      selA   = selFwd(id_use_ra, id_ra, exWe_q, exRd_q, memWe_q, memRd_q, wbWe_q, wbRd_q);
      selB   = selFwd(id_use_rb, id_rb, exWe_q, exRd_q, memWe_q, memRd_q, wbWe_q, wbRd_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exWe_q     <= 1'b0;
         exMr_q     <= 1'b0;
         exRd_q     <= '0;
         memWe_q    <= 1'b0;
         memRd_q    <= '0;
         wbWe_q     <= 1'b0;
         wbRd_q     <= '0;
         fwdA_q     <= FwdReg;
         fwdB_q     <= FwdReg;
         stallCnt_q <= '0;
      end else if (!freeze) begin
         if (bubble) begin
            exWe_q <= 1'b0;
            exMr_q <= 1'b0;
            exRd_q <= '0;
            fwdA_q <= FwdReg;
            fwdB_q <= FwdReg;
         end else begin
            exWe_q <= idWe;
            exMr_q <= id_memread;
            exRd_q <= id_rd;
            fwdA_q <= selA;
            fwdB_q <= selB;
         end
         memWe_q <= exWe_q;
         memRd_q <= exRd_q;
         wbWe_q  <= memWe_q;
         wbRd_q  <= memRd_q;
         if (stall && (stallCnt_q != '1)) begin
            stallCnt_q <= stallCnt_q + 1'b1;
         end
      end
   end

   assign fwd_a     = fwdA_q;
   assign fwd_b     = fwdB_q;
   assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: two instances (plain and zero-register with a 2-bit
// counter) share stimulus; expected selects are queued at drive time and checked after the edge.
module tb_hazard_fwd_unit;

   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          rst, id_valid, id_use_ra, id_use_rb, id_regwrite, id_memread;
   logic          ex_flush, freeze;
   logic [AW-1:0] id_ra, id_rb, id_rd;
   logic          stall, stallZ;
   logic [1:0]    fwd_a, fwd_b, fwdAZ, fwdBZ;
   logic [15:0]   stall_cnt;
   logic [1:0]    stallCntZ;

   always #5 clk = ~clk;

   hazard_fwd_unit #(.REG_AW(AW), .ZERO_REG(1'b0), .PERF_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
      .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .ex_flush(ex_flush), .freeze(freeze), .stall(stall),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
   );

   hazard_fwd_unit #(.REG_AW(AW), .ZERO_REG(1'b1), .PERF_W(2)) dutZ (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
      .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .ex_flush(ex_flush), .freeze(freeze), .stall(stallZ),
      .fwd_a(fwdAZ), .fwd_b(fwdBZ), .stall_cnt(stallCntZ)
   );

   typedef struct {
      string      tag;
      logic [1:0] a;
      logic [1:0] b;
      logic       zChk;
      logic [1:0] za;
      logic [1:0] zb;
   } exp_t;

   exp_t sbQ[$];
   int   nVec = 0;
   int   nErr = 0;
   int   cntModel = 0;

   task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic setId(input logic v, input logic [AW-1:0] ra, input logic ua,
                        input logic [AW-1:0] rb, input logic ub, input logic [AW-1:0] rd,
                        input logic rw, input logic mr);
      id_valid    = v;
      id_ra       = ra;
      id_use_ra   = ua;
      id_rb       = rb;
      id_use_rb   = ub;
      id_rd       = rd;
      id_regwrite = rw;
      id_memread  = mr;
   endtask

   task automatic nop();
      setId(1'b0, 3'd6, 1'b0, 3'd6, 1'b0, 3'd6, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [AW-1:0] rd);
      setId(1'b1, 3'd6, 1'b0, 3'd6, 1'b0, rd, 1'b1, 1'b0);
   endtask

   task automatic ld(input logic [AW-1:0] rd, input logic [AW-1:0] ra, input logic ua);
      setId(1'b1, ra, ua, 3'd6, 1'b0, rd, 1'b1, 1'b1);
   endtask

   task automatic rdop(input logic [AW-1:0] ra, input logic ua, input logic [AW-1:0] rb,
                       input logic ub);
      setId(1'b1, ra, ua, rb, ub, 3'd5, 1'b0, 1'b0);
   endtask

   // One cycle: check combinational stall, queue expected selects, clock, then score.
   task automatic step(input logic expStall, input logic [1:0] a, input logic [1:0] b,
                       input string tag, input logic zChk = 1'b0,
                       input logic [1:0] za = 2'b00, input logic [1:0] zb = 2'b00);
      exp_t e;
      #1;
      checkVal({tag, ".stall"}, {31'd0, stall}, {31'd0, expStall});
      e.tag  = tag;
      e.a    = a;
      e.b    = b;
      e.zChk = zChk;
      e.za   = za;
      e.zb   = zb;
      sbQ.push_back(e);
      if (rst) cntModel = 0;
      else if (expStall && !freeze) cntModel++;
      @(posedge clk);
      #1;
      if (sbQ.size() == 0) begin
         nVec++;
         nErr++;
         $display("FAIL %s.queue: got empty, want entry", tag);
      end else begin
         e = sbQ.pop_front();
         checkVal({e.tag, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, e.a});
         checkVal({e.tag, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, e.b});
         if (e.zChk) begin
            checkVal({e.tag, ".z.fwd_a"}, {30'd0, fwdAZ}, {30'd0, e.za});
            checkVal({e.tag, ".z.fwd_b"}, {30'd0, fwdBZ}, {30'd0, e.zb});
         end
      end
      checkVal({tag, ".cnt"}, {16'd0, stall_cnt}, cntModel);
      checkVal({tag, ".z.cnt"}, {30'd0, stallCntZ}, (cntModel > 3) ? 3 : cntModel);
   endtask

   task automatic drain();
      repeat (3) begin
         nop();
         step(1'b0, 2'd0, 2'd0, "nop");
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      rst      = 1'b1;
      ex_flush = 1'b0;
      freeze   = 1'b0;
      nop();
      step(1'b0, 2'd0, 2'd0, "reset0");
      step(1'b0, 2'd0, 2'd0, "reset1");
      rst = 1'b0;

      // Back-to-back ALU dependency
      wr(3'd1);                   step(1'b0, 2'd0, 2'd0, "add_r1");
      rdop(3'd1, 1, 3'd2, 1);     step(1'b0, 2'd1, 2'd0, "sub_r1");
      drain();

      // Producer distance 2, 3, 4 on operand b
      wr(3'd2);                   step(1'b0, 2'd0, 2'd0, "d2_prod");
      wr(3'd7);                   step(1'b0, 2'd0, 2'd0, "d2_fill");
      rdop(3'd6, 0, 3'd2, 1);     step(1'b0, 2'd0, 2'd2, "dist2");
      drain();
      wr(3'd2);                   step(1'b0, 2'd0, 2'd0, "d3_prod");
      repeat (2) begin wr(3'd7);  step(1'b0, 2'd0, 2'd0, "d3_fill"); end
      rdop(3'd6, 0, 3'd2, 1);     step(1'b0, 2'd0, 2'd3, "dist3");
      drain();
      wr(3'd2);                   step(1'b0, 2'd0, 2'd0, "d4_prod");
      repeat (3) begin wr(3'd7);  step(1'b0, 2'd0, 2'd0, "d4_fill"); end
      rdop(3'd6, 0, 3'd2, 1);     step(1'b0, 2'd0, 2'd0, "dist4");
      drain();

      // Load-use: one stall cycle, then MEM/WB select
      ld(3'd3, 3'd6, 0);          step(1'b0, 2'd0, 2'd0, "lu_load");
      rdop(3'd3, 1, 3'd6, 0);     step(1'b1, 2'd0, 2'd0, "lu_stall");
                                  step(1'b0, 2'd2, 2'd0, "lu_issue");
      drain();

      // Two in-flight writers of r4: newest wins on both ports
      wr(3'd4);                   step(1'b0, 2'd0, 2'd0, "r4_old");
      wr(3'd4);                   step(1'b0, 2'd0, 2'd0, "r4_new");
      rdop(3'd4, 1, 3'd4, 1);     step(1'b0, 2'd1, 2'd1, "r4_both");
      drain();

      // Load-use under freeze: everything held, stall still visible
      wr(3'd4);                   step(1'b0, 2'd0, 2'd0, "frz_w4");
      ld(3'd3, 3'd4, 1);          step(1'b0, 2'd1, 2'd0, "frz_load");
      rdop(3'd3, 1, 3'd6, 0);
      freeze = 1'b1;
      repeat (3)                  step(1'b1, 2'd1, 2'd0, "frz_hold");
      freeze = 1'b0;              step(1'b1, 2'd0, 2'd0, "frz_stall");
                                  step(1'b0, 2'd2, 2'd0, "frz_issue");
      drain();

      // Load-use killed by a taken branch: no stall, bubble
      wr(3'd4);                   step(1'b0, 2'd0, 2'd0, "fl_w4");
      ld(3'd3, 3'd4, 1);          step(1'b0, 2'd1, 2'd0, "fl_load");
      rdop(3'd3, 1, 3'd6, 0);
      ex_flush = 1'b1;            step(1'b0, 2'd0, 2'd0, "fl_kill");
      ex_flush = 1'b0;            step(1'b0, 2'd2, 2'd0, "fl_next");
      drain();

      // Two more load-use stalls drive the 2-bit counter into saturation
      for (int k = 0; k < 2; k++) begin
         ld(3'd3, 3'd6, 0);       step(1'b0, 2'd0, 2'd0, "sat_load");
         rdop(3'd3, 1, 3'd6, 0);  step(1'b1, 2'd0, 2'd0, "sat_stall");
                                  step(1'b0, 2'd2, 2'd0, "sat_issue");
      end
      drain();

      // r0 is tracked only when not hard-wired
      wr(3'd0);                   step(1'b0, 2'd0, 2'd0, "r0_write", 1'b1, 2'd0, 2'd0);
      rdop(3'd0, 1, 3'd0, 1);     step(1'b0, 2'd1, 2'd1, "r0_read", 1'b1, 2'd0, 2'd0);
      drain();

      // Reset between producers and consumer discards them
      wr(3'd5);                   step(1'b0, 2'd0, 2'd0, "rst_w5");
      ld(3'd3, 3'd6, 0);          step(1'b0, 2'd0, 2'd0, "rst_load");
      rst = 1'b1;
      nop();                      step(1'b0, 2'd0, 2'd0, "rst_mid");
      rst = 1'b0;
      rdop(3'd3, 1, 3'd5, 1);     step(1'b0, 2'd0, 2'd0, "rst_after", 1'b1, 2'd0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard and forwarding controller for the 5-stage pipeline. It tracks the destination tags of in-flight instructions in an internal shadow of the ID/EX, EX/MEM and MEM/WB registers, and issues registered forwarding selects for both EX operands. It also detects load-use hazards, raising a stall and inserting a bubble. Compared with the single-cycle combinational forwarding logic, it adds a third forwarding source (WB-hold), load-use stall generation, flush/freeze handling, optional hard-wired zero register and a stall performance counter.

## Interface
Parameters:
- REG_AW, 3, register-address width
- ZERO_REG, 0, 1 = register 0 is hard-wired; writes to it are never tracked or forwarded
- PERF_W, 16, stall-counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_ra, id_rb  in  REG_AW  source registers of ID instruction
- id_use_ra, id_use_rb  in  1  the source is actually read
- id_rd  in  REG_AW  destination of ID instruction
- id_regwrite  in  1  ID instruction writes id_rd
- id_memread  in  1  ID instruction is a load
- ex_flush  in  1  taken branch in EX; kill the ID instruction
- freeze  in  1  global pipeline hold (memory wait)
- stall  out  1  hold PC and IF/ID; bubble into ID/EX (combinational)
- fwd_a, fwd_b  out  2  EX operand select, registered: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB-hold
- stall_cnt  out  PERF_W  saturating count of stall cycles

## Operation
- Each of the three internal tag stages (EX, MEM, WB) holds {we, rd}. The EX stage also holds memread.
- Effective write enable: we = regwrite && !(ZERO_REG && rd==0).
- Stall condition: stall = id_valid && !ex_flush && EX.we && EX.memread && ((id_use_ra && id_ra==EX.rd) || (id_use_rb && id_rb==EX.rd)).
- Tag advance on each clk edge with !freeze:
  - EX <= bubble if (stall || ex_flush || !id_valid); otherwise {id_we, id_rd, id_memread}.
  - MEM <= EX; WB <= MEM.
- Forward select for operand a, loaded at the same edge the instruction enters EX. Compare against the pre-edge stages, priority highest first:
  - 01 if id_use_ra && EX.we && id_ra==EX.rd
  - 10 if MEM.we && id_ra==MEM.rd
  - 11 if WB.we && id_ra==WB.rd
  - else 00
- Operand b uses the same rule with id_rb / id_use_rb.
- When a bubble enters EX, fwd_a and fwd_b load 00.
- Priority selects the newest producer. An EX-stage load never yields 01, because the stall prevents that case.
- stall_cnt increments on every edge with stall && !freeze && !rst, and holds at all-ones once saturated.

## Timing
- Reset (rst high at an edge): all tag stages become bubbles (we=0, memread=0); fwd_a=fwd_b=00; stall_cnt=0. stall is 0 in the cycle after reset.
- Reset mid-operation discards all tracked producers; no forwarding occurs from instructions issued before reset.
- stall has 0-cycle latency from the ID inputs. A load-use hazard stalls exactly 1 cycle; the consumer then enters EX with select 10.
- fwd selects are valid for the whole EX cycle of their instruction and change only at non-frozen edges.
- freeze: all state is held (tags, fwd, stall_cnt); stall still reflects current inputs. If freeze and ex_flush are both asserted, freeze wins and nothing advances.
- ex_flush together with a hazard: stall=0 and a bubble enters EX.
- !id_valid: bubble, no stall.
- Distance ≥4 producers are visible through the regfile; select 00.

## Test plan
- ADD r1 followed immediately by SUB reading ra=r1 -> SUB's EX cycle: fwd_a=01, fwd_b=00, stall=0.
- Producer of r2 at distance 2, 3 and 4 from a consumer with rb=r2 -> fwd_b = 10, 11, 00 respectively.
- LD r3 followed by ADD reading ra=r3 -> stall=1 for exactly 1 cycle, bubble in EX, then fwd_a=10; stall_cnt goes 0->1.
- r4 written at distance 1 and at distance 2, consumer reads r4 on both ports -> fwd_a=fwd_b=01.
- Load-use stall with freeze held 3 cycles -> stall stays 1, fwd and stall_cnt unchanged until freeze drops. Same hazard with ex_flush=1 -> stall=0, bubble, stall_cnt unchanged.
- ZERO_REG=1: write r0, then read r0 -> fwd 00. Assert rst between producer and consumer -> consumer gets 00 and stall_cnt=0.
